// File: rtl/vga_grid_renderer.sv
// vga_grid_renderer: VGA raster timing plus tile/food palette renderer with a two-stage output pipeline.
module vga_grid_renderer #(
  parameter int          H_ACTIVE     = 640,
  parameter int          H_FP         = 16,
  parameter int          H_SYNC       = 96,
  parameter int          H_BP         = 48,
  parameter int          V_ACTIVE     = 480,
  parameter int          V_FP         = 10,
  parameter int          V_SYNC       = 2,
  parameter int          V_BP         = 33,
  parameter int          SYNC_POL     = 0,
  parameter int          TILE_LOG2    = 4,
  parameter int          GRID_W       = 40,
  parameter int          GRID_H       = 30,
  parameter int          FLASH_FRAMES = 15,
  parameter logic [15:0] COL_EMPTY    = 16'h0000,
  parameter logic [15:0] COL_BODY     = 16'h07E0,
  parameter logic [15:0] COL_HEAD     = 16'hFFE0,
  parameter logic [15:0] COL_WALL     = 16'h7BEF,
  parameter logic [15:0] COL_FOOD     = 16'hF800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  tile_kind,
  input  logic [5:0]  foodx,
  input  logic [4:0]  foody,
  input  logic        flash,
  output logic [9:0]  posx,
  output logic [9:0]  posy,
  output logic [5:0]  tile_x,
  output logic [4:0]  tile_y,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        frame_start,
  output logic [23:0] vga_out
);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HA     = 10'(H_ACTIVE);
  localparam logic [9:0] VA     = 10'(V_ACTIVE);
  localparam logic [9:0] HS0    = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS1    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS0    = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS1    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [6:0] GW     = 7'(GRID_W);
  localparam logic [5:0] GH     = 6'(GRID_H);
  localparam int         FW     = FLASH_FRAMES > 1 ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [FW-1:0] F_LAST = FW'(FLASH_FRAMES - 1);
  localparam logic       SP     = 1'(SYNC_POL);

  logic act0, hs0, vs0, in0, food0, fs0;
  logic act1, hs1, vs1, in1, food1, en1, fs1;
  logic [FW-1:0] fcnt;
  logic fph;
  logic [15:0] pal, base, c565;

  assign tile_x = 6'(posx >> TILE_LOG2);
  assign tile_y = 5'(posy >> TILE_LOG2);
  assign act0   = (posx < HA) && (posy < VA);
  assign hs0    = (posx >= HS0) && (posx <= HS1);
  assign vs0    = (posy >= VS0) && (posy <= VS1);
  assign in0    = ({1'b0, tile_x} < GW) && ({1'b0, tile_y} < GH);
  assign food0  = in0 && (tile_x == foodx) && (tile_y == foody);
  assign fs0    = (posx == 10'd0) && (posy == 10'd0);

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      posx <= 10'd0;
      posy <= 10'd0;
    end else begin
      posx <= (posx == H_LAST) ? 10'd0 : posx + 10'd1;
      if (posx == H_LAST) posy <= (posy == V_LAST) ? 10'd0 : posy + 10'd1;
    end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      {act1, hs1, vs1, in1, food1, en1, fs1} <= 7'd0;
    end else begin
      {act1, hs1, vs1, in1, food1, en1, fs1} <= {act0, hs0, vs0, in0, food0, en, fs0};
    end

  // Phase updates as pixel (0,0) enters stage 1, so the whole frame sees one phase.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      fcnt <= '0;
      fph  <= 1'b0;
    end else if (!flash) begin
      fcnt <= '0;
      fph  <= 1'b0;
    end else if (fs0) begin
      fcnt <= (fcnt == F_LAST) ? '0 : fcnt + 1'b1;
      fph  <= (fcnt == F_LAST) ? ~fph : fph;
    end

  // tile_kind arrives one cycle after tile_x/tile_y, i.e. alongside the stage-1 pixel.
  assign pal  = tile_kind == 2'd0 ? COL_EMPTY : tile_kind == 2'd1 ? COL_BODY :
                tile_kind == 2'd2 ? COL_HEAD : COL_WALL;
  assign base = food1 ? COL_FOOD : pal;
  assign c565 = !(act1 && en1 && in1) ? 16'h0000 : fph ? ~base : base;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hsync       <= ~SP;
      vsync       <= ~SP;
      de          <= 1'b0;
      frame_start <= 1'b0;
      vga_out     <= 24'h0;
    end else begin
      hsync       <= hs1 ? SP : ~SP;
      vsync       <= vs1 ? SP : ~SP;
      de          <= act1;
      frame_start <= fs1;
      vga_out     <= {c565[15:11], c565[15:13], c565[10:5], c565[10:9], c565[4:0], c565[4:2]};
    end
endmodule

// File: tb/tb_vga_grid_renderer.sv
// tb_vga_grid_renderer: table vectors, flash/reset sequences and a per-cycle raster model on a shrunken timing.
module tb_vga_grid_renderer;
  localparam int HA = 40, HF = 4, HS = 6, HB = 6, VA = 24, VF = 2, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB, FR = HT * VT;
  localparam int TL = 2, GW = 8, GH = 5, FF = 2;

  logic clk = 0, rst = 0, en = 0, flash = 0;
  logic [1:0] tile_kind = 0;
  logic [5:0] foodx = 0;
  logic [4:0] foody = 0;
  logic [9:0] posx, posy;
  logic [5:0] tile_x;
  logic [4:0] tile_y;
  logic hsync, vsync, de, frame_start;
  logic [23:0] vga_out;

  vga_grid_renderer #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(0), .TILE_LOG2(TL), .GRID_W(GW), .GRID_H(GH), .FLASH_FRAMES(FF)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .tile_kind(tile_kind), .foodx(foodx), .foody(foody),
    .flash(flash), .posx(posx), .posy(posy), .tile_x(tile_x), .tile_y(tile_y),
    .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start), .vga_out(vga_out)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int t = 0, k = 0;
  bit use_map = 0;
  logic [1:0] map [16][16];
  logic en_prev = 0;
  logic [5:0] fx_prev = 0;
  logic [4:0] fy_prev = 0;

  typedef struct {
    logic [1:0]  tk;
    logic        e;
    int          px;
    int          py;
    logic [23:0] rgb;
    logic        d;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s t=%0d got=%h exp=%h", nm, t, act, exp);
    end
  endtask

  function automatic logic [15:0] pal(input logic [1:0] kind);
    case (kind)
      2'd0: return 16'h0000;
      2'd1: return 16'h07E0;
      2'd2: return 16'hFFE0;
      default: return 16'h7BEF;
    endcase
  endfunction

  function automatic logic [23:0] model_rgb(input int x, input int y, input logic e, input logic [5:0] fx,
                                            input logic [4:0] fy, input logic [1:0] tk, input bit ph);
    int tx = x >> TL;
    int ty = y >> TL;
    logic [15:0] c;
    int r, g, b;
    if (x >= HA || y >= VA || !e || tx >= GW || ty >= GH) return '0;
    c = (tx == int'(fx) && ty == int'(fy)) ? 16'hF800 : pal(tk);
    if (ph) c = ~c;
    r = int'(c[15:11]);
    g = int'(c[10:5]);
    b = int'(c[4:0]);
    return 24'((((r << 3) | (r >> 2)) << 16) | (((g << 2) | (g >> 4)) << 8) | ((b << 3) | (b >> 2)));
  endfunction

  task automatic step();
    logic en_now, fl_now;
    logic [5:0] fx_now;
    logic [4:0] fy_now;
    logic [1:0] tk_now;
    bit ph_old;
    int p, x, y, c;
    if (use_map) begin
      c = t - 1;
      tile_kind = (c < 0) ? 2'd0 : map[((c / HT) % VT) >> TL][(c % HT) >> TL];
    end
    en_now = en; fl_now = flash; fx_now = foodx; fy_now = foody; tk_now = tile_kind;
    @(posedge clk);
    t++;
    ph_old = ((k / FF) % 2) == 1;
    if (!fl_now) k = 0;
    else if ((t - 1) % FR == 0) k++;
    #1;
    chk("posx", 32'(posx), 32'(t % HT));
    chk("posy", 32'(posy), 32'((t / HT) % VT));
    if (t < 2) begin
      chk("hsync_rst", 32'(hsync), 1);
      chk("vsync_rst", 32'(vsync), 1);
      chk("de_rst", 32'(de), 0);
      chk("fs_rst", 32'(frame_start), 0);
      chk("rgb_rst", 32'(vga_out), 0);
    end else begin
      p = t - 2;
      x = p % HT;
      y = (p / HT) % VT;
      chk("hsync", 32'(hsync), 32'(!(x >= HA + HF && x < HA + HF + HS)));
      chk("vsync", 32'(vsync), 32'(!(y >= VA + VF && y < VA + VF + VS)));
      chk("de", 32'(de), 32'(x < HA && y < VA));
      chk("frame_start", 32'(frame_start), 32'(x == 0 && y == 0));
      chk("rgb", 32'(vga_out), 32'(model_rgb(x, y, en_prev, fx_prev, fy_prev, tk_now, ph_old)));
    end
    en_prev = en_now; fx_prev = fx_now; fy_prev = fy_now;
  endtask

  task automatic wait_pixel(input int px, input int py);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(t >= 2 && (t - 2) % FR == py * HT + px) && n < FR + 4);
    if (!(t >= 2 && (t - 2) % FR == py * HT + px)) chk("wait_timeout", 32'(n), 0);
  endtask

  task automatic fill_map(input logic [1:0] v);
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) map[i][j] = v;
  endtask

  initial begin
    vec_t tv[12];
    logic [23:0] fexp[6];
    int hs_low, vs_low, fs_cnt, de_cnt, first_fs;
    tv[0]  = '{2'd0, 1'b1,  0,  0, 24'h000000, 1'b1};
    tv[1]  = '{2'd1, 1'b1,  7,  4, 24'h00FF00, 1'b1};
    tv[2]  = '{2'd1, 1'b1,  8,  4, 24'hFF0000, 1'b1};
    tv[3]  = '{2'd1, 1'b1, 11,  7, 24'hFF0000, 1'b1};
    tv[4]  = '{2'd1, 1'b1, 12,  7, 24'h00FF00, 1'b1};
    tv[5]  = '{2'd2, 1'b1, 20, 10, 24'hFFFF00, 1'b1};
    tv[6]  = '{2'd3, 1'b1, 20, 10, 24'h7B7D7B, 1'b1};
    tv[7]  = '{2'd1, 1'b1, 35, 10, 24'h000000, 1'b1};
    tv[8]  = '{2'd1, 1'b1, 45, 10, 24'h000000, 1'b0};
    tv[9]  = '{2'd1, 1'b1, 20, 22, 24'h000000, 1'b1};
    tv[10] = '{2'd1, 1'b1, 10, 26, 24'h000000, 1'b0};
    tv[11] = '{2'd1, 1'b0, 20, 10, 24'h000000, 1'b1};
    fexp = '{24'h000000, 24'hFFFFFF, 24'hFFFFFF, 24'h000000, 24'h000000, 24'hFFFFFF};

    en = 1; foodx = 2; foody = 1;
    fill_map(2'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("init_posx", 32'(posx), 0);
    chk("init_hsync", 32'(hsync), 1);
    chk("init_rgb", 32'(vga_out), 0);
    rst = 1;
    t = 0; k = 0;

    foreach (tv[i]) begin
      tile_kind = tv[i].tk;
      en = tv[i].e;
      wait_pixel(tv[i].px, tv[i].py);
      chk("tbl_rgb", 32'(vga_out), 32'(tv[i].rgb));
      chk("tbl_de", 32'(de), 32'(tv[i].d));
    end

    en = 1; foodx = 63; foody = 31; use_map = 1;
    fill_map(2'd0);
    wait_pixel(0, 27);
    flash = 1;
    for (int f = 0; f < 6; f++) begin
      wait_pixel(1, 1);
      chk("flash_rgb", 32'(vga_out), 32'(fexp[f]));
    end
    wait_pixel(0, 27);
    flash = 0;
    fill_map(2'd1);
    wait_pixel(1, 1);
    chk("flash_off_rgb", 32'(vga_out), 32'h00FF00);

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) map[i][j] = 2'($urandom_range(0, 3));
    for (int j = 0; j < 16; j += 3) map[2][j] = 2'd2;
    foodx = 6'($urandom_range(0, 9)); foody = 5'($urandom_range(0, 6));
    for (int n = 0; n < 4 * FR; n++) begin
      if ($urandom_range(0, 299) == 0) en = ~en;
      if ($urandom_range(0, 499) == 0) begin
        foodx = 6'($urandom_range(0, 9));
        foody = 5'($urandom_range(0, 6));
      end
      if ($urandom_range(0, 1999) == 0) flash = ~flash;
      if ($urandom_range(0, 99) == 0) map[$urandom_range(0, 7)][$urandom_range(0, 13)] = 2'($urandom_range(0, 3));
      step();
    end

    flash = 0;
    wait_pixel(0, 0);
    hs_low = 0; vs_low = 0; fs_cnt = 0; de_cnt = 0;
    for (int n = 0; n < FR; n++) begin
      if (n > 0) step();
      hs_low += int'(!hsync);
      vs_low += int'(!vsync);
      fs_cnt += int'(frame_start);
      de_cnt += int'(de);
    end
    chk("hsync_low_per_frame", 32'(hs_low), 32'(VT * HS));
    chk("vsync_low_per_frame", 32'(vs_low), 32'(VS * HT));
    chk("frame_start_per_frame", 32'(fs_cnt), 1);
    chk("de_per_frame", 32'(de_cnt), 32'(HA * VA));

    wait_pixel(30, 5);
    rst = 0;
    #1;
    chk("mid_rst_posx", 32'(posx), 0);
    chk("mid_rst_posy", 32'(posy), 0);
    chk("mid_rst_hsync", 32'(hsync), 1);
    chk("mid_rst_vsync", 32'(vsync), 1);
    chk("mid_rst_de", 32'(de), 0);
    chk("mid_rst_fs", 32'(frame_start), 0);
    chk("mid_rst_rgb", 32'(vga_out), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("held_rst_posx", 32'(posx), 0);
    rst = 1;
    t = 0; k = 0;
    first_fs = -1;
    for (int n = 0; n < 10 && first_fs < 0; n++) begin
      step();
      if (frame_start) first_fs = t;
    end
    chk("first_fs_after_rst", 32'(first_fs), 2);
    repeat (200) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
